// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers and a fixed-latency busy window.
// Define MDU_DIV_EN to build the divider; without it div/divu behave like the reserved opcode.
module mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state   | meaning
    // IDLE    | accepts start; mthi/mtlo write HI/LO directly
    // RUN     | multiply/divide in flight, counter counts down to 0, then commit
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_wr;
    logic               start_mul, start_div;
    logic [CW-1:0]      div_cnt;

    // Sign-extending both operands makes the low 2*WIDTH bits of the product the signed result.
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, a_q};
        b_ext = {{WIDTH{1'b0}}, b_q};
        if (op_q == OP_MULT) begin
            a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end
        prod = a_ext * b_ext;
    end

    assign start_mul = (op == OP_MULT) || (op == OP_MULTU);

`ifdef MDU_DIV_EN
    localparam logic [2:0]    OP_DIV  = 3'b011;
    localparam logic [2:0]    OP_DIVU = 3'b100;
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag;

    // Magnitude division; most-negative / -1 wraps back to most-negative with zero remainder.
    always_comb begin
        a_neg = (op_q == OP_DIV) && a_q[WIDTH-1];
        b_neg = (op_q == OP_DIV) && b_q[WIDTH-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
    end

    always_comb begin
        res_wr = 1'b1;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            res_wr = (b_q != '0);
            res_hi = a_neg ? -r_mag : r_mag;
            res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        end
    end

    assign start_div = (op == OP_DIV) || (op == OP_DIVU);
    assign div_cnt   = DIV_CNT;
`else
    assign res_wr    = 1'b1;
    assign res_hi    = prod[2*WIDTH-1:WIDTH];
    assign res_lo    = prod[WIDTH-1:0];
    assign start_div = 1'b0;
    assign div_cnt   = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_mul || start_div) begin
                        state_d = ST_RUN;
                        cnt_d   = start_mul ? MUL_CNT : div_cnt;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
